addr_arbiter: RTL and testbench
===============================

Name: addr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 3-to-8 select decoder.
- Collects per-target requests, picks one winner and drives the decoder's address/valid inputs. The decoder's one-hot sel output then enables the granted target.
- Each grant is held until the target signals done, drops its request, or exceeds a hold-time limit.

Parameters:
N, 8, number of requesters/decoder outputs; power of two, 2..256
ADDR_W, $clog2(N) = 3, width of address output
HOLD_MAX, 16, max cycles a grant may be held before forced release; range 2..2^16

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector, bit i = requester i wants the select line
done  input  1  current grant holder releases the grant this cycle
address  output  ADDR_W  granted index, drives decoder address
valid  output  1  grant active, drives decoder valid
timeout  output  1  one-cycle pulse when a grant is forcibly released

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, address=0, valid=0, timeout=0, ptr=0, hold_cnt=0.
  - Outputs go low immediately, also mid-grant.
  - First rising edge after rst_n rises performs normal evaluation.
- All outputs are registered; no combinational path from req or done to outputs.
- Pick function: first index i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N). Lowest offset from ptr wins.
- IDLE state:
  - If req=0: stay IDLE, valid=0.
  - Otherwise, next edge: address=pick(req, ptr), valid=1, hold_cnt=0, state GRANT.
  - Latency: req rise to valid high is one cycle.
  - done in IDLE is ignored.
- GRANT state: address stable and valid=1 while none of the release conditions holds; hold_cnt increments each cycle. Release conditions:
  - (a) done=1
  - (b) req[address]=0
  - (c) hold_cnt = HOLD_MAX-1
- On release at edge E:
  - ptr becomes (address+1) mod N.
  - Re-arbitration uses req with bit [address] masked off, searching from the new ptr.
  - If a winner exists: address=winner, valid stays 1, hold_cnt=0, state stays GRANT (back-to-back, no bubble).
  - Otherwise: valid=0, address holds its last value, state IDLE.
- Simultaneous conditions: (a) and (b) together count as a single normal release. Condition (c) coinciding with (a) or (b) counts as a normal release, so timeout is not asserted.
- timeout: set to 1 for exactly the cycle after a release caused solely by (c); 0 otherwise.
- Wrap-around: address=N-1 released gives ptr=0. ptr is ADDR_W bits and wraps naturally.
- Single requester that stays asserted:
  - (a)/(c) release finds no other requester, so valid drops for one cycle.
  - The following edge re-grants the same index.
  - Guarantees the decoder sees a valid gap between successive grants to the same target.
- hold_cnt width: $clog2(HOLD_MAX) bits; saturation is never reached because (c) releases first.
- Invariant: valid=1 implies address < N and req[address] was 1 on the granting edge.

Decomposition:
- Package arb_pkg: state enum {IDLE, GRANT}, default constants N_DEF=8, HOLD_MAX_DEF=16.
- Sub-module rr_pick (combinational, parameterised N):
  - Inputs: req vector, ptr, mask index, mask enable.
  - Outputs: found, index.
  - Instantiated once in addr_arbiter and shared by the IDLE and release paths.

Test Plan:
- Reset mid-grant: grant index 5, assert rst_n=0 between edges -> valid=0, address=0, timeout=0 immediately; after release with req=0, valid stays 0.
- Single request: req=8'b0000_1000 from IDLE -> next cycle address=3, valid=1; done=1 one cycle -> valid=0 next cycle, then address=3, valid=1 again the cycle after.
- Round-robin fairness: req=8'hFF, done pulsed every 2nd cycle -> grant sequence 0,1,2,…,7,0 with no valid gap; the decoder downstream sees sel=01,02,04,…,80,01.
- Wrap pick: grant 6 active, req=8'b0100_0001, done=1 -> next address=0 (search 7,0), valid stays 1.
- Timeout: req=8'b0000_0100 held, done never asserted -> valid high for exactly 16 cycles, timeout=1 in the cycle after release, valid=0 that cycle, re-grant of 2 next cycle.
- Request drop: grant 4 active, req[4] deasserted with req[1]=1 -> next cycle address=1, valid=1, timeout=0.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and default constants for the round-robin
//                address arbiter and its pick helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter FSM: IDLE waits for any request, GRANT holds a winner
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_DEF        = 8;
    localparam int HOLD_MAX_DEF = 16;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit searching ptr, ptr+1, ... modulo N, optionally
//                ignoring one masked index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [ADDR_W-1:0] ptr,
    input  logic [ADDR_W-1:0] mask_idx,
    input  logic              mask_en,
    output logic              found,
    output logic [ADDR_W-1:0] index
);

    // Walk offsets 0..N-1 from ptr; N is a power of two so the index wraps
    // naturally in ADDR_W bits. The first eligible hit is latched by 'found'.
    always_comb begin
        logic [ADDR_W-1:0] w_idx;
        found = 1'b0;
        index = '0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = ptr + ADDR_W'(k);
            if (!found && req[w_idx] && !(mask_en && (w_idx == mask_idx))) begin
                found = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/addr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addr_arbiter
//  Description : Round-robin arbiter feeding a select decoder. Picks one
//                requester, drives address/valid, and holds the grant until
//                done, request drop, or a hold-time limit forces release.
//                Release re-arbitrates in the same edge (no bubble) with the
//                outgoing index masked off.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int ADDR_W   = $clog2(N),
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              valid,
    output logic              timeout
);

    localparam int HOLD_W = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_address;
    logic              r_valid;
    logic              r_timeout;
    logic [ADDR_W-1:0] r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic              w_rel_done;
    logic              w_rel_drop;
    logic              w_rel_hold;
    logic              w_release;
    logic              w_in_grant;
    logic [ADDR_W-1:0] w_pick_ptr;
    logic              w_found;
    logic [ADDR_W-1:0] w_winner;

    // Release conditions evaluated against the currently held grant
    assign w_in_grant = (r_state == GRANT);
    assign w_rel_done = done;
    assign w_rel_drop = ~req[r_address];
    assign w_rel_hold = (r_hold_cnt == c_HOLD_LAST);
    assign w_release  = w_rel_done | w_rel_drop | w_rel_hold;

    // In GRANT the picker only matters on release, where the new pointer is
    // address+1 and the outgoing index is excluded; in IDLE it uses ptr.
    assign w_pick_ptr = w_in_grant ? (r_address + ADDR_W'(1)) : r_ptr;

    rr_pick #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_pick (
        .req      (req),
        .ptr      (w_pick_ptr),
        .mask_idx (r_address),
        .mask_en  (w_in_grant),
        .found    (w_found),
        .index    (w_winner)
    );

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_address  <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_found) begin
                        r_address  <= w_winner;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= GRANT;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr     <= r_address + ADDR_W'(1);
                        // Only a pure hold-limit release counts as forced
                        r_timeout <= w_rel_hold & ~w_rel_done & ~w_rel_drop;
                        if (w_found) begin
                            r_address  <= w_winner;
                            r_valid    <= 1'b1;
                            r_hold_cnt <= '0;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        r_timeout  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign address = r_address;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule : addr_arbiter
`default_nettype wire

// File: tb/tb_addr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_arbiter
//  Description : Self-checking bench for addr_arbiter: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_arbiter;

    localparam int N        = 8;
    localparam int ADDR_W   = 3;
    localparam int HOLD_MAX = 16;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic              done;
    logic [ADDR_W-1:0] address;
    logic              valid;
    logic              timeout;

    int n_checks;
    int n_errors;

    // Reference model state
    bit m_valid;
    int m_addr;
    int m_ptr;
    int m_held;
    bit m_timeout;

    addr_arbiter #(
        .N        (N),
        .ADDR_W   (ADDR_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .address (address),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First requester at or after 'start' (circularly), skipping 'skip'
    function automatic int ref_pick(input logic [N-1:0] r, input int start, input int skip);
        for (int off = 0; off < N; off++) begin
            int i;
            i = (start + off) % N;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_addr = 0; m_ptr = 0; m_held = 0; m_timeout = 0;
    endfunction

    // One clock edge of the arbiter's rules, given the inputs seen at it
    function automatic void model_edge(input logic [N-1:0] r, input bit d);
        int w;
        if (!m_valid) begin
            m_timeout = 0;
            w = ref_pick(r, m_ptr, -1);
            if (w >= 0) begin
                m_valid = 1; m_addr = w; m_held = 1;
            end
        end else begin
            bit by_done, by_drop, by_time;
            by_done = d;
            by_drop = !r[m_addr];
            by_time = (m_held == HOLD_MAX);
            if (by_done || by_drop || by_time) begin
                m_timeout = by_time && !by_done && !by_drop;
                m_ptr = (m_addr + 1) % N;
                w = ref_pick(r, m_ptr, m_addr);
                if (w >= 0) begin
                    m_addr = w; m_held = 1;
                end else begin
                    m_valid = 0;
                end
            end else begin
                m_held++;
                m_timeout = 0;
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".valid"},   32'(valid),   32'(m_valid));
        chk({tag, ".address"}, 32'(address), 32'(m_addr));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
    endtask

    // Apply inputs, clock once, check DUT against model just after the edge
    task automatic step(input logic [N-1:0] r, input bit d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        model_edge(r, d);
        compare_model(tag);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int vcount;
        logic [N-1:0] r;
        bit d;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset.valid",   32'(valid),   0);
        chk("reset.address", 32'(address), 0);
        chk("reset.timeout", 32'(timeout), 0);
        rst_n = 1'b1;

        // Round-robin over all requesters, done every second cycle
        step(8'hFF, 0, "rr_first");
        chk("rr_first_addr", 32'(address), 0);
        for (int k = 1; k <= 8; k++) begin
            step(8'hFF, 1, "rr_move");
            chk("rr_addr",  32'(address), 32'(k % 8));
            chk("rr_valid", 32'(valid), 1);
            step(8'hFF, 0, "rr_hold");
        end

        // Single request: grant, release via done, gap, re-grant
        do_reset();
        step(8'h08, 0, "single_grant");
        chk("single_addr", 32'(address), 3);
        chk("single_valid", 32'(valid), 1);
        step(8'h08, 1, "single_done");
        chk("single_gap", 32'(valid), 0);
        step(8'h08, 0, "single_regrant");
        chk("single_regrant_addr", 32'(address), 3);
        chk("single_regrant_valid", 32'(valid), 1);

        // Wrap pick: from 6, search 7 then 0
        do_reset();
        step(8'h40, 0, "wrap_grant6");
        chk("wrap_addr6", 32'(address), 6);
        step(8'h41, 1, "wrap_release");
        chk("wrap_addr0", 32'(address), 0);
        chk("wrap_valid", 32'(valid), 1);

        // Timeout: lone requester held, done never asserted
        do_reset();
        vcount = 0;
        step(8'h04, 0, "to_grant");
        while (valid && vcount < 40) begin
            vcount++;
            step(8'h04, 0, "to_hold");
        end
        chk("to_valid_cycles", 32'(vcount), 16);
        chk("to_pulse", 32'(timeout), 1);
        chk("to_gap_valid", 32'(valid), 0);
        step(8'h04, 0, "to_regrant");
        chk("to_regrant_addr", 32'(address), 2);
        chk("to_regrant_valid", 32'(valid), 1);
        chk("to_pulse_clear", 32'(timeout), 0);

        // Request drop: 4 granted, 4 drops while 1 requests
        do_reset();
        step(8'h10, 0, "drop_grant4");
        step(8'h02, 0, "drop_switch");
        chk("drop_addr", 32'(address), 1);
        chk("drop_valid", 32'(valid), 1);
        chk("drop_timeout", 32'(timeout), 0);

        // Asynchronous reset mid-grant
        do_reset();
        step(8'h20, 0, "arst_grant5");
        chk("arst_pre_addr", 32'(address), 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(valid),   0);
        chk("arst_address", 32'(address), 0);
        chk("arst_timeout", 32'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(8'h00, 0, "arst_after");
        chk("arst_after_valid", 32'(valid), 0);

        // Randomized traffic in phases of differing request density
        for (int ph = 0; ph < 40; ph++) begin
            int mode;
            mode = $urandom_range(0, 3);
            if (ph % 13 == 12) do_reset();
            r = N'($urandom);
            for (int c = 0; c < 60; c++) begin
                case (mode)
                    0: begin r = N'($urandom); d = ($urandom_range(0, 3) == 0); end
                    1: begin
                        if ($urandom_range(0, 15) == 0) r = N'(1) << $urandom_range(0, N-1);
                        d = 1'b0;
                    end
                    2: begin
                        if ($urandom_range(0, 7) == 0) r = N'($urandom) & N'($urandom);
                        d = ($urandom_range(0, 9) == 0);
                    end
                    default: begin r = N'($urandom) | N'($urandom); d = $urandom_range(0, 1) == 1; end
                endcase
                step(r, d, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_addr_arbiter
`default_nettype wire
